// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - fetch-stage program counter with circular return-address stack
module pc_unit_ras #(
  parameter int               WIDTH        = 16,
  parameter int               INC          = 1,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4,
  localparam int              PTR_W        = $clog2(RAS_DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             PCWrite,
  input  logic [1:0]       Mode,
  input  logic             Call,
  input  logic [WIDTH-1:0] Offset,
  input  logic [WIDTH-1:0] Target,
  input  logic             FlagClr,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCPlus,
  output logic [PTR_W:0]   StackCount,
  output logic             Overflow,
  output logic             Underflow
);

  localparam logic [1:0]       MODE_SEQ    = 2'b00;
  localparam logic [1:0]       MODE_BRANCH = 2'b01;
  localparam logic [1:0]       MODE_JUMP   = 2'b10;
  localparam logic [WIDTH-1:0] INC_W       = WIDTH'(INC);
  localparam logic [PTR_W:0]   DEPTH_C     = (PTR_W+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] stack [RAS_DEPTH];
  logic [PTR_W-1:0] wp_q;
  logic [PTR_W-1:0] wp_top;
  logic [PTR_W-1:0] wp_d;
  logic [PTR_W:0]   count_d;
  logic [WIDTH-1:0] stack_top;
  logic [WIDTH-1:0] next_pc;
  logic             is_ret;
  logic             push;
  logic             pop;
  logic             underflow_evt;
  logic             overflow_evt;
  logic             ovf_d;
  logic             unf_d;

  assign PCPlus    = PCResult + INC_W;
  assign wp_top    = wp_q - PTR_W'(1);
  assign stack_top = stack[wp_top];

  // Decode the operation for this cycle and compute next PC, pointer, count and flags
  always_comb begin
    is_ret        = (Mode == 2'b11);
    push          = PCWrite && Call && !is_ret;
    pop           = PCWrite && is_ret && (StackCount != '0);
    underflow_evt = PCWrite && is_ret && (StackCount == '0);
    overflow_evt  = push && (StackCount == DEPTH_C);
    next_pc       = PCPlus;
    wp_d          = wp_q;
    count_d       = StackCount;

    case (Mode)
      MODE_SEQ:    next_pc = PCPlus;
      MODE_BRANCH: next_pc = PCResult + Offset;
      MODE_JUMP:   next_pc = Target;
      default:     next_pc = pop ? stack_top : PCPlus;
    endcase

    // A full stack keeps its count and simply overwrites the oldest slot
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
      if (StackCount != DEPTH_C) count_d = StackCount + (PTR_W+1)'(1);
    end else if (pop) begin
      wp_d    = wp_top;
      count_d = StackCount - (PTR_W+1)'(1);
    end

    // A set event beats a clear in the same cycle
    ovf_d = overflow_evt  ? 1'b1 : (FlagClr ? 1'b0 : Overflow);
    unf_d = underflow_evt ? 1'b1 : (FlagClr ? 1'b0 : Underflow);
  end

  // PC, stack pointer, count and sticky flags; stall holds all but the flag clear
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      PCResult   <= RESET_VECTOR;
      wp_q       <= '0;
      StackCount <= '0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      if (PCWrite) begin
        PCResult   <= next_pc;
        wp_q       <= wp_d;
        StackCount <= count_d;
      end
      Overflow  <= ovf_d;
      Underflow <= unf_d;
    end
  end

  // Return-address storage; contents are don't-care after reset, but a reset cycle never pushes
  always_ff @(posedge Clk) begin
    if (Reset_n && push) stack[wp_q] <= PCPlus;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - scoreboard bench for pc_unit_ras
module tb_pc_unit_ras;

  localparam logic [1:0] SEQ = 2'b00, BR = 2'b01, JMP = 2'b10, RET = 2'b11;

  logic        Clk = 1'b0;
  logic        Reset_n, PCWrite, Call, FlagClr;
  logic [1:0]  Mode;
  logic [15:0] Offset, Target;
  logic [15:0] PCResult, PCPlus;
  logic [2:0]  StackCount;
  logic        Overflow, Underflow;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic        rn, w, c, fc;
    logic [1:0]  m;
    logic [15:0] off, tgt;
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        ovf, unf;
  } st_t;

  st_t sbq[$];

  pc_unit_ras #(.WIDTH(16), .INC(1), .RESET_VECTOR(16'h0100), .RAS_DEPTH(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .PCWrite(PCWrite), .Mode(Mode), .Call(Call),
    .Offset(Offset), .Target(Target), .FlagClr(FlagClr), .PCResult(PCResult),
    .PCPlus(PCPlus), .StackCount(StackCount), .Overflow(Overflow), .Underflow(Underflow)
  );

  always #5 Clk = ~Clk;

  function automatic st_t mk(string n, logic rn, logic w, logic [1:0] m, logic c,
                             logic [15:0] off, logic [15:0] tgt, logic fc,
                             logic [15:0] pc, logic [2:0] cnt, logic ovf, logic unf);
    st_t s;
    s.name = n; s.rn = rn; s.w = w; s.m = m; s.c = c; s.off = off; s.tgt = tgt;
    s.fc = fc; s.pc = pc; s.cnt = cnt; s.ovf = ovf; s.unf = unf;
    return s;
  endfunction

  task automatic drive(input st_t s);
    Reset_n = s.rn; PCWrite = s.w; Mode = s.m; Call = s.c;
    Offset = s.off; Target = s.tgt; FlagClr = s.fc;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    st_t t[$];
    st_t e;
    t.push_back(mk("reset", 0, 1, SEQ, 0, 0, 0, 0, 16'h0100, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
    total++;
    if (PCPlus !== 16'h0101) $display("FAIL reset_pcplus: got %h want 0101", PCPlus);
    else passed++;
  endtask

  task automatic test_seq_stall();
    st_t t[$];
    st_t e;
    t.push_back(mk("seq1",   1, 1, SEQ, 0, 0, 0, 0, 16'h0101, 0, 0, 0));
    t.push_back(mk("seq2",   1, 1, SEQ, 0, 0, 0, 0, 16'h0102, 0, 0, 0));
    t.push_back(mk("seq3",   1, 1, SEQ, 0, 0, 0, 0, 16'h0103, 0, 0, 0));
    t.push_back(mk("stall1", 1, 0, SEQ, 0, 0, 0, 0, 16'h0103, 0, 0, 0));
    t.push_back(mk("stall_call_ignored", 1, 0, JMP, 1, 0, 16'h0555, 0, 16'h0103, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
  endtask

  task automatic test_branch_jump();
    st_t t[$];
    st_t e;
    t.push_back(mk("jump_fffe",   1, 1, JMP, 0, 0, 16'hFFFE, 0, 16'hFFFE, 0, 0, 0));
    t.push_back(mk("branch_wrap", 1, 1, BR,  0, 16'h0003, 0, 0, 16'h0001, 0, 0, 0));
    t.push_back(mk("jump_1234",   1, 1, JMP, 0, 0, 16'h1234, 0, 16'h1234, 0, 0, 0));
    t.push_back(mk("branch_neg",  1, 1, BR,  0, 16'hFFFE, 0, 0, 16'h1232, 0, 0, 0));
    t.push_back(mk("seq_wrap_in", 1, 1, JMP, 0, 0, 16'hFFFF, 0, 16'hFFFF, 0, 0, 0));
    t.push_back(mk("seq_wrap",    1, 1, SEQ, 0, 0, 0, 0, 16'h0000, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
  endtask

  task automatic test_call_return();
    st_t t[$];
    st_t e;
    t.push_back(mk("goto_0010",   1, 1, JMP, 0, 0, 16'h0010, 0, 16'h0010, 0, 0, 0));
    t.push_back(mk("call_jump",   1, 1, JMP, 1, 0, 16'h0200, 0, 16'h0200, 1, 0, 0));
    t.push_back(mk("call_branch", 1, 1, BR,  1, 16'h0010, 0, 0, 16'h0210, 2, 0, 0));
    t.push_back(mk("ret_branch",  1, 1, RET, 0, 0, 0, 0, 16'h0201, 1, 0, 0));
    t.push_back(mk("ret_jump",    1, 1, RET, 1, 0, 0, 0, 16'h0011, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    st_t t[$];
    st_t e;
    t.push_back(mk("goto_a0", 1, 1, JMP, 0, 0, 16'h00A0, 0, 16'h00A0, 0, 0, 0));
    t.push_back(mk("call1",   1, 1, JMP, 1, 0, 16'h00A1, 0, 16'h00A1, 1, 0, 0));
    t.push_back(mk("call2",   1, 1, JMP, 1, 0, 16'h00A2, 0, 16'h00A2, 2, 0, 0));
    t.push_back(mk("call3",   1, 1, JMP, 1, 0, 16'h00A3, 0, 16'h00A3, 3, 0, 0));
    t.push_back(mk("call4",   1, 1, JMP, 1, 0, 16'h00A4, 0, 16'h00A4, 4, 0, 0));
    t.push_back(mk("call5_ovf", 1, 1, JMP, 1, 0, 16'h00A5, 0, 16'h00A5, 4, 1, 0));
    t.push_back(mk("ret1",    1, 1, RET, 0, 0, 0, 0, 16'h00A5, 3, 1, 0));
    t.push_back(mk("ret2",    1, 1, RET, 0, 0, 0, 0, 16'h00A4, 2, 1, 0));
    t.push_back(mk("ret3",    1, 1, RET, 0, 0, 0, 0, 16'h00A3, 1, 1, 0));
    t.push_back(mk("ret4",    1, 1, RET, 0, 0, 0, 0, 16'h00A2, 0, 1, 0));
    t.push_back(mk("ret5_unf", 1, 1, RET, 0, 0, 0, 0, 16'h00A3, 0, 1, 1));
    t.push_back(mk("clr_in_stall", 1, 0, SEQ, 0, 0, 0, 1, 16'h00A3, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    st_t t[$];
    st_t e;
    t.push_back(mk("unf_beats_clr", 1, 1, RET, 0, 0, 0, 1, 16'h00A4, 0, 0, 1));
    t.push_back(mk("clr_unf",       1, 1, SEQ, 0, 0, 0, 1, 16'h00A5, 0, 0, 0));
    t.push_back(mk("call_then",     1, 1, JMP, 1, 0, 16'h0300, 0, 16'h0300, 1, 0, 0));
    t.push_back(mk("reset_mid_call", 0, 1, JMP, 1, 0, 16'h0777, 0, 16'h0100, 0, 0, 0));
    t.push_back(mk("ret_after_rst", 1, 1, RET, 0, 0, 0, 0, 16'h0101, 0, 0, 1));
    t.push_back(mk("reset_flags",   0, 1, SEQ, 0, 0, 0, 0, 16'h0100, 0, 0, 0));
    for (int i = 0; i < t.size(); i++) begin
      sbq.push_back(t[i]); drive(t[i]); e = sbq.pop_front(); total++;
      if ({PCResult, StackCount, Overflow, Underflow} !== {e.pc, e.cnt, e.ovf, e.unf})
        $display("FAIL %s: pc=%h cnt=%0d ovf=%b unf=%b want pc=%h cnt=%0d ovf=%b unf=%b",
                 e.name, PCResult, StackCount, Overflow, Underflow, e.pc, e.cnt, e.ovf, e.unf);
      else passed++;
    end
  endtask

  initial begin
    Reset_n = 1'b0; PCWrite = 1'b0; Mode = SEQ; Call = 1'b0;
    Offset = '0; Target = '0; FlagClr = 1'b0;
    test_reset();
    test_seq_stall();
    test_branch_jump();
    test_call_return();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
